// File: rtl/stepper_step_seq.sv
// Step sequencer feeding decoder2_4: turns a move command into a 2-bit phase
// index, tracks signed absolute position and holds coil drive after a move.
module stepper_step_seq #(
    parameter int STEPS_W  = 16,
    parameter int DIV_W    = 20,
    parameter int POS_W    = 24,
    parameter int HOLD_CYC = 1000000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               dir_i,
    input  logic [STEPS_W-1:0] steps_i,
    input  logic [DIV_W-1:0]   period_i,
    output logic [1:0]         cnt_o,
    output logic [POS_W-1:0]   pos_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               en_o
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [STEPS_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   per_q, per_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               en_q, en_d;

    logic               end_move;
    logic [DIV_W-1:0]   period_eff;

    assign period_eff = (period_i == '0) ? DIV_W'(1) : period_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            div_q   <= '0;
            per_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            per_q   <= per_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // (which would infer a latch); done_d defaults to 0 to make it a pulse.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        div_d    = div_q;
        per_d    = per_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        en_d     = en_q;
        end_move = 1'b0;

        unique case (state_q)
            S_IDLE, S_HOLD: begin
                if (start_i && !stop_i) begin
                    state_d = S_RUN;
                    dir_d   = dir_i;
                    rem_d   = steps_i;
                    per_d   = period_eff;
                    div_d   = period_eff;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                end else if (state_q == S_HOLD) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    end_move = 1'b1;
                end else if (rem_q == '0) begin
                    end_move = 1'b1;
                    done_d   = 1'b1;
                end else if (div_q <= DIV_W'(1)) begin
                    cnt_d = dir_q ? cnt_q + 2'd1 : cnt_q - 2'd1;
                    pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    div_d = per_q;
                    rem_d = rem_q - STEPS_W'(1);
                    if (rem_q == STEPS_W'(1)) begin
                        end_move = 1'b1;
                        done_d   = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Normal completion and abort share the same exit into hold or idle.
        if (end_move) begin
            busy_d = 1'b0;
            if (HOLD_CYC != 0) begin
                state_d = S_HOLD;
                hold_d  = HOLD_LOAD;
            end else begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign pos_o  = pos_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign en_o   = en_q;

endmodule

// File: tb/tb_stepper_step_seq.sv
// Directed bench for stepper_step_seq (HOLD_CYC=4): cycle-by-cycle vector
// table plus hand-written sequences for abort, ignored START and reset.
module tb_stepper_step_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, dir;
    logic [15:0] steps;
    logic [19:0] period;
    logic [1:0]  cnt;
    logic [23:0] pos;
    logic        busy, done, en;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n, start, stop, dir;
        logic [15:0] steps;
        logic [19:0] period;
        logic [1:0]  cnt;
        logic [23:0] pos;
        logic        busy, done, en;
    } vec_t;

    vec_t tbl[$];

    stepper_step_seq #(
        .STEPS_W (16),
        .DIV_W   (20),
        .POS_W   (24),
        .HOLD_CYC(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .stop_i  (stop),
        .dir_i   (dir),
        .steps_i (steps),
        .period_i(period),
        .cnt_o   (cnt),
        .pos_o   (pos),
        .busy_o  (busy),
        .done_o  (done),
        .en_o    (en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] e_cnt, input logic [23:0] e_pos,
                         input logic e_busy, input logic e_done, input logic e_en);
        n_vec++;
        if ({cnt, pos, busy, done, en} !== {e_cnt, e_pos, e_busy, e_done, e_en}) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d pos=%h busy=%b done=%b en=%b, want cnt=%0d pos=%h busy=%b done=%b en=%b",
                     name, cnt, pos, busy, done, en, e_cnt, e_pos, e_busy, e_done, e_en);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic p, input logic d,
                       input logic [15:0] n, input logic [19:0] per,
                       input logic [1:0] c, input logic [23:0] q,
                       input logic b, input logic dn, input logic e);
        vec_t v;
        v.rst_n = r;  v.start = s; v.stop = p;  v.dir = d;
        v.steps = n;  v.period = per;
        v.cnt = c;    v.pos = q;   v.busy = b;  v.done = dn; v.en = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic d,
                         input logic [15:0] n, input logic [19:0] per);
        rst_n = r; start = s; stop = p; dir = d; steps = n; period = per;
    endtask

    initial begin
        logic done_seen;
        drive(0, 0, 0, 0, 0, 0);

        // Reset held for two edges.
        tick(); check("reset_1", 0, 0, 0, 0, 0);
        tick(); check("reset_2", 0, 0, 0, 0, 0);

        // Forward 5 steps, period 3, then 4-cycle hold.
        add(1, 1, 0, 1, 5, 3,   0, 24'd0, 1, 0, 1);
        for (int i = 0; i < 2; i++) add(1, 0, 0, 1, 5, 3, 0, 24'd0, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 5, 3, 1, 24'd1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 5, 3, 2, 24'd2, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 5, 3, 3, 24'd3, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 5, 3, 0, 24'd4, 1, 0, 1);
        add(1, 0, 0, 1, 5, 3,   1, 24'd5, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1, 24'd5, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,   1, 24'd5, 0, 0, 0);
        // STOP beats START in IDLE.
        add(1, 1, 1, 0, 3, 1,   1, 24'd5, 0, 0, 0);
        // Reset back to origin, then reverse 2 steps with PERIOD=0.
        add(0, 0, 0, 0, 0, 0,   0, 24'd0, 0, 0, 0);
        add(1, 1, 0, 0, 2, 0,   0, 24'd0, 1, 0, 1);
        add(1, 0, 0, 0, 2, 0,   3, 24'hFFFFFF, 1, 0, 1);
        add(1, 0, 0, 0, 2, 0,   2, 24'hFFFFFE, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0,   2, 24'hFFFFFE, 0, 0, 1);
        // START with STEPS=0 from HOLD: EN never drops, busy one cycle.
        add(1, 1, 0, 1, 0, 7,   2, 24'hFFFFFE, 1, 0, 1);
        add(1, 0, 0, 1, 0, 7,   2, 24'hFFFFFE, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 2, 24'hFFFFFE, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,   2, 24'hFFFFFE, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].stop, tbl[i].dir, tbl[i].steps, tbl[i].period);
            tick();
            check($sformatf("tbl[%0d]", i), tbl[i].cnt, tbl[i].pos, tbl[i].busy, tbl[i].done, tbl[i].en);
        end

        // STOP on the 3rd step edge (PERIOD=4); START mid-run is ignored.
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 1, 5, 4); tick();
        check("stop_start", 0, 24'd0, 1, 0, 1);
        done_seen = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 2) drive(1, 1, 0, 0, 1, 1);
            else        drive(1, 0, (e == 12), 0, 0, 0);
            tick();
            done_seen |= done;
            if (e == 4)  check("stop_step1", 1, 24'd1, 1, 0, 1);
            if (e == 8)  check("stop_step2", 2, 24'd2, 1, 0, 1);
            if (e == 11) check("stop_pre",   2, 24'd2, 1, 0, 1);
            if (e == 12) check("stop_edge",  2, 24'd2, 0, 0, 1);
        end
        n_vec++;
        if (done_seen !== 1'b0) begin
            n_err++;
            $display("FAIL stop_no_done: got done pulse=%b, want 0", done_seen);
        end
        // STOP held during HOLD is ignored; EN drops after exactly 4 cycles.
        for (int h = 1; h <= 4; h++) begin
            drive(1, 0, 1, 0, 0, 0);
            tick();
            check($sformatf("stop_hold%0d", h), 2, 24'd2, 0, 0, (h < 4));
        end

        // Reset in the middle of a move.
        drive(1, 1, 0, 1, 3, 1); tick();
        drive(1, 0, 0, 1, 3, 1); tick();
        check("mid_step", 3, 24'd3, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0); tick();
        check("mid_reset", 0, 24'd0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0); tick();
        check("post_reset", 0, 24'd0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
